// File: rtl/nios2_mult_cell_pipe_pkg.sv
// Package nios2_mult_pkg: shared definitions for the Nios II pipelined multiplier.
//   OP_*        op encodings on the 2-bit op port
//   n_slices()  number of SLICE_W-wide slices per DATA_W operand
//   cfg_ok()    legality of a DATA_W/SLICE_W pairing, checked at elaboration
package nios2_mult_pkg;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;

    function automatic int n_slices(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    function automatic bit cfg_ok(input int data_w, input int slice_w);
        return (slice_w > 0) && (data_w >= slice_w) && (data_w <= 64) &&
               ((data_w % slice_w) == 0);
    endfunction

endpackage

// File: rtl/nios2_mult_cell_pipe_if.sv
// Handshake/data bundle between the execute stage and the multiplier.
//   master: drives in_valid/src1/src2/op and out_ready; sees in_ready/out_valid/result
//   slave : the multiplier side (opposite directions)
interface nios2_mult_cell_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [1:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;

    modport master (
        output in_valid, src1, src2, op, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, src1, src2, op, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/nios2_mult_cell_pipe_slice.sv
// nios2_mult_slice: one registered (SLICE_W+1)x(SLICE_W+1) signed multiply.
//   clk, reset_n     clock, async active-low reset (clears the product)
//   en               load enable (pipeline advance)
//   a, a_sign        operand slice and its extension bit (sign for the top
//                    slice of a signed operand, zero otherwise)
//   b, b_sign        same for the second operand
//   p                registered signed product, 2*SLICE_W+2 bits
module nios2_mult_slice #(
    parameter int SLICE_W = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic [SLICE_W-1:0]          a,
    input  logic                        a_sign,
    input  logic [SLICE_W-1:0]          b,
    input  logic                        b_sign,
    output logic signed [2*SLICE_W+1:0] p
);
    logic signed [SLICE_W:0] a_ext;
    logic signed [SLICE_W:0] b_ext;

    assign a_ext = {a_sign, a};
    assign b_ext = {b_sign, b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (en) begin
            p <= a_ext * b_ext;
        end
    end
endmodule

// File: rtl/nios2_mult_cell_pipe.sv
// nios2_mult_cell_pipe: stallable 3-stage DATA_W x DATA_W integer multiplier.
//   clk      single clock, rising edge
//   reset_n  async active-low reset; clears valids and all data registers
//   flush    sync; drops every in-flight operation on the next edge
//   bus      nios2_mult_cell_pipe_if.slave (in_valid/in_ready/src1/src2/op,
//            out_valid/out_ready/result)
// Stages: S1 operands, S2 slice products, S3 shift-add + half select.
// A single enable (adv) moves every stage, so a held result stalls the
// whole pipe and in_ready equals adv.
// Build option NIOS2_MULT_CELL_MULX_EN: when defined, the full 2*DATA_W
// product is built and op selects signedness and half (MULX*); otherwise the
// slice pairs that only feed the high half are pruned, op is ignored and the
// low half is always returned.
module nios2_mult_cell_pipe
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    nios2_mult_cell_pipe_if.slave bus
);
    localparam int NS = n_slices(DATA_W, SLICE_W);
    localparam int PW = 2*SLICE_W + 2;
    localparam int SW = 2*DATA_W + 2;
`ifdef NIOS2_MULT_CELL_MULX_EN
    localparam bit FULL_PRODUCT = 1'b1;
`else
    localparam bit FULL_PRODUCT = 1'b0;
`endif

    if (!cfg_ok(DATA_W, SLICE_W)) begin : g_cfg_err
        $error("nios2_mult_cell_pipe: DATA_W must be a multiple of SLICE_W and <= 64");
    end

    logic                    adv;
    logic                    ld;
    logic                    v1;
    logic                    v2;
    logic                    out_valid_q;
    logic [DATA_W-1:0]       result_q;
    logic [DATA_W-1:0]       result_d;
    logic [DATA_W-1:0]       a_q;
    logic [DATA_W-1:0]       b_q;
    logic                    a_sgn;
    logic                    b_sgn;
    logic signed [PW-1:0]    prod [NS][NS];
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    term;

    assign adv          = ~out_valid_q | bus.out_ready;
    // Data registers keep their contents across a flush; only valids drop.
    assign ld           = adv & ~flush;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    // S1: operands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1  <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (flush) begin
                v1 <= 1'b0;
            end else if (adv) begin
                v1 <= bus.in_valid;
            end
            if (ld) begin
                a_q <= bus.src1;
                b_q <= bus.src2;
            end
        end
    end

`ifdef NIOS2_MULT_CELL_MULX_EN
    logic [1:0] op1_q;
    logic [1:0] op2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op1_q <= OP_MUL;
            op2_q <= OP_MUL;
        end else if (ld) begin
            op1_q <= bus.op;
            op2_q <= op1_q;
        end
    end

    assign a_sgn = (op1_q == OP_MULXSU) || (op1_q == OP_MULXSS);
    assign b_sgn = (op1_q == OP_MULXSS);
`else
    assign a_sgn = 1'b0;
    assign b_sgn = 1'b0;
`endif

    // S2: slice products; only the top slice of each operand carries a sign.
    for (genvar i = 0; i < NS; i++) begin : g_row
        for (genvar j = 0; j < NS; j++) begin : g_col
            if (FULL_PRODUCT || (i + j < NS)) begin : g_mul
                nios2_mult_slice #(
                    .SLICE_W (SLICE_W)
                ) u_slice (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .en      (ld),
                    .a       (a_q[i*SLICE_W +: SLICE_W]),
                    .a_sign  ((i == NS-1) ? (a_sgn & a_q[DATA_W-1]) : 1'b0),
                    .b       (b_q[j*SLICE_W +: SLICE_W]),
                    .b_sign  ((j == NS-1) ? (b_sgn & b_q[DATA_W-1]) : 1'b0),
                    .p       (prod[i][j])
                );
            end else begin : g_pruned
                assign prod[i][j] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2 <= 1'b0;
        end else if (flush) begin
            v2 <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
        end
    end

    // S3: shift-add tree. Sum width covers the widest shifted slice product;
    // arithmetic wraps, so bits above 2*DATA_W never matter.
    always_comb begin
        sum  = '0;
        term = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                term = prod[i][j];
                sum  = sum + (term << (SLICE_W*(i+j)));
            end
        end
    end

`ifdef NIOS2_MULT_CELL_MULX_EN
    assign result_d = (op2_q == OP_MUL) ? sum[DATA_W-1:0] : sum[2*DATA_W-1:DATA_W];
    logic unused_bits;
    assign unused_bits = ^sum[SW-1:2*DATA_W];
`else
    assign result_d = sum[DATA_W-1:0];
    logic unused_bits;
    assign unused_bits = ^{sum[SW-1:DATA_W], bus.op};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (adv) begin
                out_valid_q <= v2;
            end
            if (ld) begin
                result_q <= result_d;
            end
        end
    end
endmodule

// File: tb/tb_nios2_mult_cell_pipe.sv
module tb_nios2_mult_cell_pipe;
    logic clk;
    logic reset_n;
    logic flush;

    int tests;
    int fails;
    logic [31:0] exp_q[$];

    nios2_mult_cell_pipe_if #(.DATA_W(32)) bus ();

    nios2_mult_cell_pipe #(
        .DATA_W  (32),
        .SLICE_W (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product of the two extended operands; the 64-bit
    // wraparound still yields the correct low and high 32-bit halves.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o);
        longint ea;
        longint eb;
        longint p;
        logic [63:0] pb;
        bit mulx;
`ifdef NIOS2_MULT_CELL_MULX_EN
        mulx = 1'b1;
`else
        mulx = 1'b0;
`endif
        if (mulx && (o == 2'd2 || o == 2'd3)) ea = $signed(a);
        else                                  ea = longint'({32'd0, a});
        if (mulx && o == 2'd3) eb = $signed(b);
        else                   eb = longint'({32'd0, b});
        p  = ea * eb;
        pb = p;
        if (mulx && o != 2'd0) return pb[63:32];
        return pb[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every accepted result against the queue.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none", bus.result);
                end else begin
                    check("result", {32'd0, bus.result}, {32'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer, in_valid still high.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.src1     = a;
        bus.src2     = b;
        bus.op       = o;
        forever begin
            #3;
            if (bus.in_ready && !flush) begin
                exp_q.push_back(model(a, b, o));
                @(negedge clk);
                return;
            end
            @(negedge clk);
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got in_ready=%0b expected 1", bus.in_ready);
                return;
            end
        end
    endtask

    // Entered at the negedge after acceptance (cycle 1 after the transfer).
    task automatic wait_out(input string name, input int exp_lat);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(name, lat, exp_lat);
    endtask

    task automatic run_len(input string name, input int exp_n);
        int w;
        int n;
        w = 0;
        n = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        while (bus.out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp_n);
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int acc;
        int cyc;
        int w;

        tests         = 0;
        fails         = 0;
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.op        = 2'd0;
        bus.out_ready = 1'b1;

        #1;
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_result", {32'd0, bus.result}, 64'd0);
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic latency and value
        send(32'h0001_0003, 32'h0002_0005, 2'd0);
        bus.in_valid = 1'b0;
        wait_out("basic_latency", 3);
        check("basic_result", {32'd0, bus.result}, 64'h0000_0000_000B_000F);
        repeat (3) @(negedge clk);

        // Signedness, back-to-back
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'd1);
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'd2);
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'd3);
        bus.in_valid = 1'b0;
        run_len("sign_run", 3);
`ifdef NIOS2_MULT_CELL_MULX_EN
        check("sign_model_uu", {32'd0, model(32'hFFFF_FFFF, 32'h2, 2'd1)}, 64'h1);
`endif
        repeat (2) @(negedge clk);

        // Stall with three ops queued
        bus.out_ready = 1'b0;
        send(32'h0000_1234, 32'h0000_0010, 2'd0);
        send(32'h8000_0001, 32'h7FFF_FFFF, 2'd3);
        send(32'hDEAD_BEEF, 32'h0000_0003, 2'd2);
        bus.in_valid = 1'b0;
        check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
        r0 = bus.result;
        repeat (4) @(negedge clk);
        check("stall_result_hold", {32'd0, bus.result}, {32'd0, r0});
        check("stall_in_ready_hold", {63'd0, bus.in_ready}, 64'd0);
        check("stall_queued", exp_q.size(), 3);
        bus.out_ready = 1'b1;
        run_len("stall_drain_run", 3);
        check("stall_drained", exp_q.size(), 0);

        // Flush with two ops in flight and in_valid high
        send(32'h1111_1111, 32'h2222_2222, 2'd1);
        send(32'h3333_3333, 32'h4444_4444, 2'd0);
        flush    = 1'b1;
        bus.src1 = 32'h5555_5555;
        exp_q.delete();
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
            @(negedge clk);
        end
        send(32'h0000_0007, 32'h0000_0009, 2'd0);
        bus.in_valid = 1'b0;
        wait_out("flush_next_latency", 3);
        check("flush_next_result", {32'd0, bus.result}, 64'd63);
        repeat (2) @(negedge clk);

        // Mid-stream async reset
        send(32'hCAFE_0001, 32'h0000_0101, 2'd0);
        send(32'h0BAD_F00D, 32'h0000_0003, 2'd0);
        bus.in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midreset_result", {32'd0, bus.result}, 64'd0);
        check("midreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(32'h0000_0100, 32'h0000_0100, 2'd0);
        bus.in_valid = 1'b0;
        wait_out("postreset_latency", 3);
        repeat (3) @(negedge clk);

        // Random operands/ops with random backpressure
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            case ($urandom_range(0, 7))
                0:       a = 32'd0;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            o = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.src1      = a;
            bus.src2      = b;
            bus.op        = o;
            #3;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(a, b, o));
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("random_accepted", acc, 10000);
        check("random_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
